// File: rtl/cordic_sched_pkg.sv
// Shared types and constants for the CORDIC round-robin scheduler.
package cordic_sched_pkg;

  // Signed 2-bit mode encoding understood by the CORDIC core.
  localparam logic [1:0] HYPERBOLIC = 2'b11;
  localparam logic [1:0] LINEAR     = 2'b00;
  localparam logic [1:0] CIRCULAR   = 2'b01;

  // Wide enough for the largest supported requester count (8).
  localparam int TAG_ID_W = 3;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DRAINED
  } sched_state_t;

  // One delay-line entry: marks an operation in flight and its owner.
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/cordic_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at i_ptr and wraps
// modulo N, returning a one-hot grant for the first active request.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic          o_any
);

  logic w_found;

  // Pick the first requester at or after the pointer, wrapping around.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    o_gnt   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!w_found && i_req[j] && (j == (int'(i_ptr) + k) % N)) begin
          o_gnt[j] = 1'b1;
          w_found  = 1'b1;
        end
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/cordic_rr_scheduler.sv
// Round-robin scheduler sharing one fixed-latency pipelined CORDIC core
// among N_REQ requesters. An ID delay line matched to the core latency
// routes each result back to its issuer; a drain FSM quiesces the core.
// Optional build macro: CORDIC_SCHED_STATS_EN adds per-requester 16-bit
// saturating issue counters (o_issue_cnt) with a synchronous clear.
module cordic_rr_scheduler
  import cordic_sched_pkg::*;
#(
  parameter  int N_REQ        = 4,
  parameter  int BITS         = 33,
  parameter  int CORE_LATENCY = 13,
  localparam int ID_W         = $clog2(N_REQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [N_REQ*BITS-1:0] i_x,
  input  logic [N_REQ*BITS-1:0] i_y,
  input  logic [N_REQ*BITS-1:0] i_z,
  input  logic [N_REQ*2-1:0]    i_mode,
  input  logic [N_REQ-1:0]      i_rot_en,
  output logic [N_REQ-1:0]      o_gnt,
  output logic                  o_core_ready,
  output logic [BITS-1:0]       o_core_x,
  output logic [BITS-1:0]       o_core_y,
  output logic [BITS-1:0]       o_core_z,
  output logic [1:0]            o_core_mode,
  output logic                  o_core_rot_en,
  input  logic                  i_core_valid,
  input  logic [BITS-1:0]       i_core_x,
  input  logic [BITS-1:0]       i_core_y,
  input  logic [BITS-1:0]       i_core_z,
  output logic [N_REQ-1:0]      o_res_valid,
  output logic [BITS-1:0]       o_res_x,
  output logic [BITS-1:0]       o_res_y,
  output logic [BITS-1:0]       o_res_z,
  output logic [ID_W-1:0]       o_res_id,
  input  logic                  i_drain,
  output logic                  o_idle,
  output logic                  o_err
`ifdef CORDIC_SCHED_STATS_EN
  ,
  output logic [N_REQ*16-1:0]   o_issue_cnt,
  input  logic                  i_stats_clr
`endif
);

  localparam int CNT_W = $clog2(CORE_LATENCY + 2) + 1;

  sched_state_t           r_state, w_state_next;
  logic [ID_W-1:0]        r_ptr;
  logic [N_REQ-1:0]       w_arb_gnt, w_gnt;
  logic                   w_arb_any, w_grant_en, w_issue;
  logic [ID_W-1:0]        w_gnt_idx;
  logic [BITS-1:0]        w_sel_x, w_sel_y, w_sel_z;
  logic [1:0]             w_sel_mode;
  logic                   w_sel_rot;
  tag_t                   r_tag [CORE_LATENCY+1];
  tag_t                   w_tail;
  logic [CNT_W-1:0]       r_inflight;
  logic [N_REQ-1:0]       w_tail_onehot;

  rr_arbiter #(.N(N_REQ), .PW(ID_W)) u_arb (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_any (w_arb_any)
  );

  // Grants are only given while running; reset forces them low at once.
  assign w_gnt   = w_grant_en ? w_arb_gnt : '0;
  assign w_issue = w_grant_en & w_arb_any;
  assign o_gnt   = w_gnt;

  // Select the granted slot's operands and encode its index.
  always_comb begin
    w_gnt_idx  = '0;
    w_sel_x    = '0;
    w_sel_y    = '0;
    w_sel_z    = '0;
    w_sel_mode = '0;
    w_sel_rot  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_arb_gnt[k]) begin
        w_gnt_idx  = ID_W'(k);
        w_sel_x    = i_x[k*BITS +: BITS];
        w_sel_y    = i_y[k*BITS +: BITS];
        w_sel_z    = i_z[k*BITS +: BITS];
        w_sel_mode = i_mode[k*2 +: 2];
        w_sel_rot  = i_rot_en[k];
      end
    end
  end

  // Round-robin pointer moves past the winner only when a grant occurs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (w_issue) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_ptr <= (w_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  // Issue register: strobe for one cycle, operands hold between issues.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_core_ready  <= 1'b0;
      o_core_x      <= '0;
      o_core_y      <= '0;
      o_core_z      <= '0;
      o_core_mode   <= '0;
      o_core_rot_en <= 1'b0;
    end else begin
      o_core_ready <= w_issue;
      if (w_issue) begin
        o_core_x      <= w_sel_x;
        o_core_y      <= w_sel_y;
        o_core_z      <= w_sel_z;
        o_core_mode   <= w_sel_mode;
        o_core_rot_en <= w_sel_rot;
      end
    end
  end

  // Tag delay line: stage 0 is loaded alongside the issue strobe, so the
  // tail lines up with the cycle the core raises its valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: this delay line is cleared on reset because stale valid bits would misroute results; plain data arrays need no reset.
      for (int i = 0; i <= CORE_LATENCY; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= '{valid: w_issue, id: TAG_ID_W'(w_gnt_idx)};
      for (int i = 1; i <= CORE_LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign w_tail = r_tag[CORE_LATENCY];

  // Decode the tail owner into a one-hot result strobe.
  always_comb begin
    w_tail_onehot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_tail.id == TAG_ID_W'(k)) w_tail_onehot[k] = 1'b1;
    end
  end

  // Registered result bus; a tag/valid disagreement raises a sticky error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_res_valid <= '0;
      o_res_x     <= '0;
      o_res_y     <= '0;
      o_res_z     <= '0;
      o_res_id    <= '0;
      o_err       <= 1'b0;
    end else begin
      o_res_valid <= (w_tail.valid && i_core_valid) ? w_tail_onehot : '0;
      if (w_tail.valid && i_core_valid) begin
        o_res_x  <= i_core_x;
        o_res_y  <= i_core_y;
        o_res_z  <= i_core_z;
        o_res_id <= w_tail.id[ID_W-1:0];
      end
      if (w_tail.valid != i_core_valid) o_err <= 1'b1;
    end
  end

  // In-flight count: issues add one, retirements at the tail subtract one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inflight <= '0;
    end else begin
      unique case ({o_core_ready, w_tail.valid})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Drain FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= RUN;
    else          r_state <= w_state_next;
  end

  // Drain FSM next state and outputs.
  always_comb begin
    w_state_next = r_state;
    w_grant_en   = 1'b0;
    o_idle       = 1'b0;
    unique case (r_state)
      RUN: begin
        w_grant_en = i_rst_n;
        if (i_drain) w_state_next = DRAIN;
      end
      DRAIN: begin
        if (!i_drain)                                    w_state_next = RUN;
        else if (r_inflight == '0 && !o_core_ready)      w_state_next = DRAINED;
      end
      DRAINED: begin
        o_idle = 1'b1;
        if (!i_drain) w_state_next = RUN;
      end
      default: w_state_next = RUN;
    endcase
  end

`ifdef CORDIC_SCHED_STATS_EN
  logic [15:0] r_issue_cnt [N_REQ];

  // Per-requester saturating issue counters; clear wins over increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < N_REQ; k++) r_issue_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (i_stats_clr)                                 r_issue_cnt[k] <= '0;
        else if (w_gnt[k] && r_issue_cnt[k] != 16'hFFFF) r_issue_cnt[k] <= r_issue_cnt[k] + 16'd1;
      end
    end
  end

  // Flatten the counters onto the output bus.
  always_comb begin
    o_issue_cnt = '0;
    for (int k = 0; k < N_REQ; k++) o_issue_cnt[k*16 +: 16] = r_issue_cnt[k];
  end
`endif

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Self-checking bench for cordic_rr_scheduler with a stub fixed-latency core.
module tb_cordic_rr_scheduler;

  localparam int N    = 4;
  localparam int BITS = 33;
  localparam int LAT  = 13;

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_gnt;
  } vec_t;

  typedef struct {
    int              due;
    int              id;
    logic [BITS-1:0] x;
    logic [BITS-1:0] y;
    logic [BITS-1:0] z;
  } exp_t;

  logic              clk, rst_n;
  logic [N-1:0]      i_req, i_rot_en;
  logic [N*BITS-1:0] i_x, i_y, i_z;
  logic [N*2-1:0]    i_mode;
  logic [N-1:0]      o_gnt, o_res_valid;
  logic              o_core_ready, o_core_rot_en, i_core_valid;
  logic [BITS-1:0]   o_core_x, o_core_y, o_core_z;
  logic [1:0]        o_core_mode;
  logic [BITS-1:0]   i_core_x, i_core_y, i_core_z;
  logic [BITS-1:0]   o_res_x, o_res_y, o_res_z;
  logic [1:0]        o_res_id;
  logic              i_drain, o_idle, o_err;
`ifdef CORDIC_SCHED_STATS_EN
  logic [N*16-1:0]   o_issue_cnt;
  logic              i_stats_clr;
`endif

  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   last_gnt_cyc = 0;
  int   seed     = 100;
  logic inj      = 1'b0;
  exp_t q[$];
  vec_t tbl[17];

  // Slot modes: 0 hyperbolic, 1 linear, 2 and 3 circular; slot 3 vectoring.
  logic [7:0] modes_v = {2'b01, 2'b01, 2'b00, 2'b11};
  logic [3:0] rots_v  = 4'b0111;

  cordic_rr_scheduler #(.N_REQ(N), .BITS(BITS), .CORE_LATENCY(LAT)) dut (
`ifdef CORDIC_SCHED_STATS_EN
    .o_issue_cnt   (o_issue_cnt),
    .i_stats_clr   (i_stats_clr),
`endif
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req         (i_req),
    .i_x           (i_x),
    .i_y           (i_y),
    .i_z           (i_z),
    .i_mode        (i_mode),
    .i_rot_en      (i_rot_en),
    .o_gnt         (o_gnt),
    .o_core_ready  (o_core_ready),
    .o_core_x      (o_core_x),
    .o_core_y      (o_core_y),
    .o_core_z      (o_core_z),
    .o_core_mode   (o_core_mode),
    .o_core_rot_en (o_core_rot_en),
    .i_core_valid  (i_core_valid),
    .i_core_x      (i_core_x),
    .i_core_y      (i_core_y),
    .i_core_z      (i_core_z),
    .o_res_valid   (o_res_valid),
    .o_res_x       (o_res_x),
    .o_res_y       (o_res_y),
    .o_res_z       (o_res_z),
    .o_res_id      (o_res_id),
    .i_drain       (i_drain),
    .o_idle        (o_idle),
    .o_err         (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub core transform: x passes, y inverts, z adds signed mode plus rot_en.
  function automatic logic [BITS-1:0] core_z(input logic [BITS-1:0] z, input logic [1:0] m, input logic r);
    return z + {{(BITS-2){m[1]}}, m} + {{(BITS-1){1'b0}}, r};
  endfunction

  function automatic logic [BITS-1:0] op_x(input int s, input int k);
    logic [31:0] v = 32'(s) * 32'h0001_0001 + 32'(k * 17 + 3);
    return {v[0] ^ 1'(k), v};
  endfunction
  function automatic logic [BITS-1:0] op_y(input int s, input int k);
    return BITS'(32'(s) * 32'd7 + 32'(k * 3 + 5));
  endfunction
  function automatic logic [BITS-1:0] op_z(input int s, input int k);
    return BITS'(32'(s) * 32'd11 + 32'(k));
  endfunction

  // Fixed-latency core model with its own reset.
  logic [LAT-1:0]  cv;
  logic [BITS-1:0] cx [LAT];
  logic [BITS-1:0] cy [LAT];
  logic [BITS-1:0] cz [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cv <= '0;
    else begin
      cv    <= {cv[LAT-2:0], o_core_ready};
      cx[0] <= o_core_x;
      cy[0] <= ~o_core_y;
      cz[0] <= core_z(o_core_z, o_core_mode, o_core_rot_en);
      for (int i = 1; i < LAT; i++) begin
        cx[i] <= cx[i-1];
        cy[i] <= cy[i-1];
        cz[i] <= cz[i-1];
      end
    end
  end
  assign i_core_valid = cv[LAT-1] | inj;
  assign i_core_x     = cx[LAT-1];
  assign i_core_y     = cy[LAT-1];
  assign i_core_z     = cz[LAT-1];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_ops(input int s);
    for (int k = 0; k < N; k++) begin
      i_x[k*BITS +: BITS] = op_x(s, k);
      i_y[k*BITS +: BITS] = op_y(s, k);
      i_z[k*BITS +: BITS] = op_z(s, k);
    end
  endtask

  // One cycle: drive requests, check grant, queue the expected result,
  // then check the registered issue to the core.
  task automatic apply_cycle(input logic [3:0] req, input logic [3:0] exp_gnt);
    int   slot;
    int   s;
    exp_t e;
    s = seed;
    seed++;
    set_ops(s);
    i_req = req;
    @(negedge clk);
    check("gnt", {124'd0, o_gnt}, {124'd0, exp_gnt});
    slot = -1;
    for (int k = 0; k < N; k++) if (exp_gnt[k]) slot = k;
    if (slot >= 0) begin
      e.due = cyc + LAT + 2;
      e.id  = slot;
      e.x   = op_x(s, slot);
      e.y   = ~op_y(s, slot);
      e.z   = core_z(op_z(s, slot), modes_v[slot*2 +: 2], rots_v[slot]);
      q.push_back(e);
      last_gnt_cyc = cyc;
    end
    @(posedge clk);
    #1;
    check("core_ready", {127'd0, o_core_ready}, {127'd0, slot >= 0});
    if (slot >= 0) begin
      check("core_ops", {29'd0, o_core_x, o_core_y, o_core_z},
            {29'd0, op_x(s, slot), op_y(s, slot), op_z(s, slot)});
      check("core_mode", {125'd0, o_core_mode, o_core_rot_en},
            {125'd0, modes_v[slot*2 +: 2], rots_v[slot]});
    end
  endtask

  // Result monitor: compare each due result against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() > 0 && q[0].due < cyc) begin
        check("res_missing", 128'(cyc), 128'(q[0].due));
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        check("res_valid", {124'd0, o_res_valid}, 128'(4'b0001 << q[0].id));
        check("res_id", {126'd0, o_res_id}, 128'(q[0].id));
        check("res_data", {29'd0, o_res_x, o_res_y, o_res_z}, {29'd0, q[0].x, q[0].y, q[0].z});
        void'(q.pop_front());
      end else if (o_res_valid != '0) begin
        check("res_unexpected", {124'd0, o_res_valid}, 128'd0);
      end
    end
  end

  task automatic wait_empty();
    for (int i = 0; i < 40 && q.size() > 0; i++) @(posedge clk);
    #1;
    check("queue_empty", 128'(q.size()), 128'd0);
  endtask

  initial begin
    int idle_cyc;
    tbl = '{
      '{4'b0000, 4'b0000}, '{4'b0100, 4'b0100}, '{4'b0101, 4'b0001},
      '{4'b1111, 4'b0010}, '{4'b1011, 4'b1000}, '{4'b1000, 4'b1000},
      '{4'b0110, 4'b0010}, '{4'b0001, 4'b0001}, '{4'b1000, 4'b1000},
      '{4'b1111, 4'b0001}, '{4'b1111, 4'b0010}, '{4'b1111, 4'b0100},
      '{4'b1111, 4'b1000}, '{4'b1111, 4'b0001}, '{4'b1111, 4'b0010},
      '{4'b1111, 4'b0100}, '{4'b1111, 4'b1000}
    };
    rst_n    = 1'b0;
    i_req    = 4'hF;
    i_drain  = 1'b0;
    i_mode   = modes_v;
    i_rot_en = rots_v;
    set_ops(0);
`ifdef CORDIC_SCHED_STATS_EN
    i_stats_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", {124'd0, o_gnt}, 128'd0);
    check("rst_outs", {125'd0, o_core_ready, o_idle, o_err}, 128'd0);
    check("rst_res", {124'd0, o_res_valid}, 128'd0);
    i_req = '0;
    rst_n = 1'b1;

    // Table: grant order under assorted request patterns, then a burst.
    for (int v = 0; v < 17; v++) apply_cycle(tbl[v].req, tbl[v].exp_gnt);
    i_req = '0;
    wait_empty();

    // Drain with five operations in flight; requests during drain are held.
    apply_cycle(4'hF, 4'b0001);
    apply_cycle(4'hF, 4'b0010);
    apply_cycle(4'hF, 4'b0100);
    apply_cycle(4'hF, 4'b1000);
    apply_cycle(4'hF, 4'b0001);
    i_drain = 1'b1;
    apply_cycle(4'h0, 4'b0000);
    idle_cyc = -1;
    for (int i = 0; i < 40 && idle_cyc < 0; i++) begin
      apply_cycle(4'hF, 4'b0000);
      if (o_idle) idle_cyc = cyc;
    end
    check("idle_cycle", 128'(idle_cyc), 128'(last_gnt_cyc + 16));
    i_drain = 1'b0;
    apply_cycle(4'hF, 4'b0000);
    apply_cycle(4'hF, 4'b0010);
    check("idle_after_run", {127'd0, o_idle}, 128'd0);
    i_req = '0;
    wait_empty();

    // Spurious core valid with an empty delay line.
    check("err_before", {127'd0, o_err}, 128'd0);
    inj = 1'b1;
    @(posedge clk);
    #1;
    inj = 1'b0;
    @(negedge clk);
    check("err_set", {127'd0, o_err}, 128'd1);
    check("spur_res_valid", {124'd0, o_res_valid}, 128'd0);
    repeat (5) @(posedge clk);
    #1;
    check("err_sticky", {127'd0, o_err}, 128'd1);

    // Asynchronous reset in mid-stream.
    apply_cycle(4'hF, 4'b0100);
    apply_cycle(4'hF, 4'b1000);
    apply_cycle(4'hF, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    check("mid_rst_gnt", {124'd0, o_gnt}, 128'd0);
    check("mid_rst_outs", {125'd0, o_core_ready, o_idle, o_err}, 128'd0);
    check("mid_rst_core", {29'd0, o_core_x, o_core_y, o_core_z}, 128'd0);
    check("mid_rst_res", {26'd0, o_res_valid, o_res_x, o_res_y, o_res_z, o_res_id}, 128'd0);
`ifdef CORDIC_SCHED_STATS_EN
    check("mid_rst_stats", {64'd0, o_issue_cnt}, 128'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply_cycle(4'hF, 4'b0001);
    i_req = '0;
    wait_empty();
    check("err_after_rst", {127'd0, o_err}, 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
